// File: rtl/map_renderer_pkg.sv
// bomberman_pkg: shared geometry, colour constants and pixel type for the map renderer.
package bomberman_pkg;
  localparam int TILE_LOG2  = 5;
  localparam int MAP_COLS   = 20;
  localparam int MAP_ROWS   = 15;
  localparam int MAP_BITS   = MAP_COLS * MAP_ROWS;
  localparam int H_ACTIVE   = 640;
  localparam int V_ACTIVE   = 480;
  localparam int BLINK_BITS = 5;
  localparam logic [23:0] COL_BG     = 24'h00A000;
  localparam logic [23:0] COL_WALL   = 24'h808080;
  localparam logic [23:0] COL_EDGE   = 24'h404040;
  localparam logic [23:0] COL_PLAYER = 24'hFFFFFF;
  localparam logic [23:0] COL_OVER   = 24'hFF0000;
  localparam logic [23:0] COL_BLACK  = 24'h000000;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;
endpackage

// File: rtl/map_renderer_if.sv
// map_renderer_if: VGA timing, game state and RGB signals between game logic and renderer.
interface map_renderer_if;
  import bomberman_pkg::*;
  logic [9:0]          DrawX;
  logic [9:0]          DrawY;
  logic                de;
  logic                VS;
  logic [MAP_BITS-1:0] map_1d;
  logic [9:0]          playerX;
  logic [9:0]          playerY;
  logic                over;
  logic [7:0]          Red;
  logic [7:0]          Green;
  logic [7:0]          Blue;
  logic                de_out;
  modport master (output DrawX, DrawY, de, VS, map_1d, playerX, playerY, over,
                  input  Red, Green, Blue, de_out);
  modport slave  (input  DrawX, DrawY, de, VS, map_1d, playerX, playerY, over,
                  output Red, Green, Blue, de_out);
endinterface

// File: rtl/map_renderer_tile_addr.sv
// tile_addr: maps a screen pixel to its tile index, in-tile offsets and visibility.
module tile_addr
  import bomberman_pkg::*;
(
  input  logic [9:0]           x,
  input  logic [9:0]           y,
  output logic [8:0]           idx,
  output logic [TILE_LOG2-1:0] ox,
  output logic [TILE_LOG2-1:0] oy,
  output logic                 in_view
);
  logic [8:0] col, row;
  assign col = 9'(x[9:TILE_LOG2]);
  assign row = 9'(y[9:TILE_LOG2]);
  // row*20 without a multiplier
  assign idx = (row << 4) + (row << 2) + col;
  assign ox = x[TILE_LOG2-1:0];
  assign oy = y[TILE_LOG2-1:0];
  assign in_view = (x < 10'(H_ACTIVE)) && (y < 10'(V_ACTIVE));
endmodule

// File: rtl/map_renderer.sv
// map_renderer: per-frame game-state snapshot and 2-stage tile/colour pixel pipeline.
module map_renderer
  import bomberman_pkg::*;
(
  input logic           Clk,
  input logic           Reset_n,
  map_renderer_if.slave bus
);
  logic                  vs_q, over_s, frame_start, overlay_on;
  logic [MAP_BITS-1:0]   map_s;
  logic [9:0]            px_s, py_s;
  logic [BLINK_BITS-1:0] blink_cnt;
  logic [8:0]            idx, idx_q;
  logic [TILE_LOG2-1:0]  ox, oy, ox_q, oy_q;
  logic                  in_view, in_view_q, de_q, de_o, hit, hit_q, wall, tile_edge;
  logic [10:0]           dx, dy;
  rgb_t                  pix, pix_q;
  tile_addr u_tile (.x(bus.DrawX), .y(bus.DrawY), .idx, .ox, .oy, .in_view);
  assign frame_start = vs_q & ~bus.VS;
  assign overlay_on  = over_s & ~blink_cnt[BLINK_BITS-1];
  always_comb begin
    // 11-bit wrap makes pixels left of/above the sprite compare large
    dx = {1'b0, bus.DrawX} - {1'b0, px_s};
    dy = {1'b0, bus.DrawY} - {1'b0, py_s};
    hit = (dx < 11'(1 << TILE_LOG2)) && (dy < 11'(1 << TILE_LOG2));
    wall = in_view_q && map_s[idx_q];
    tile_edge = (ox_q == '0) || (ox_q == '1) || (oy_q == '0) || (oy_q == '1);
    pix = !in_view_q ? rgb_t'(COL_BLACK)  :
          overlay_on ? rgb_t'(COL_OVER)   :
          hit_q      ? rgb_t'(COL_PLAYER) :
          wall       ? (tile_edge ? rgb_t'(COL_EDGE) : rgb_t'(COL_WALL)) :
                       rgb_t'(COL_BG);
  end
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      vs_q      <= 1'b1;
      map_s     <= '0;
      px_s      <= '0;
      py_s      <= '0;
      over_s    <= 1'b0;
      blink_cnt <= '0;
      idx_q     <= '0;
      ox_q      <= '0;
      oy_q      <= '0;
      in_view_q <= 1'b0;
      hit_q     <= 1'b0;
      de_q      <= 1'b0;
      pix_q     <= '0;
      de_o      <= 1'b0;
    end else begin
      vs_q <= bus.VS;
      if (frame_start) begin
        map_s     <= bus.map_1d;
        px_s      <= bus.playerX;
        py_s      <= bus.playerY;
        over_s    <= bus.over;
        blink_cnt <= over_s ? blink_cnt + 1'b1 : '0;
      end
      idx_q     <= idx;
      ox_q      <= ox;
      oy_q      <= oy;
      in_view_q <= in_view;
      hit_q     <= hit;
      de_q      <= bus.de;
      pix_q     <= pix;
      de_o      <= de_q;
    end
  end
  assign bus.Red    = pix_q.r;
  assign bus.Green  = pix_q.g;
  assign bus.Blue   = pix_q.b;
  assign bus.de_out = de_o;
endmodule

// File: tb/tb_map_renderer.sv
// tb_map_renderer: scoreboard bench with a behavioural frame/pixel model of the renderer.
module tb_map_renderer;
  import bomberman_pkg::*;
  typedef struct {
    logic [23:0] rgb;
    int unsigned cyc;
    int          x;
    int          y;
  } exp_t;
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  map_renderer_if ifc ();
  map_renderer dut (.Clk(Clk), .Reset_n(Reset_n), .bus(ifc));
  always #5 Clk = ~Clk;
  int unsigned cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;
  int n_checks = 0;
  int n_fail = 0;
  exp_t q[$];
  logic [299:0] m_map = '0;
  int  m_px = 0, m_py = 0, m_blink = 0;
  bit  m_over = 1'b0;
  function automatic logic [23:0] model(int x, int y);
    if (x >= 640 || y >= 480) return 24'h000000;
    if (m_over && m_blink < 16) return 24'hFF0000;
    if (x >= m_px && x < m_px + 32 && y >= m_py && y < m_py + 32) return 24'hFFFFFF;
    if (m_map[(y / 32) * 20 + x / 32])
      return (x % 32 == 0 || x % 32 == 31 || y % 32 == 0 || y % 32 == 31) ? 24'h404040 : 24'h808080;
    return 24'h00A000;
  endfunction
  task automatic pix(int x, int y);
    exp_t e;
    @(posedge Clk); #1;
    ifc.DrawX = 10'(x);
    ifc.DrawY = 10'(y);
    ifc.de = 1'b1;
    e.rgb = model(x, y); e.cyc = cyc; e.x = x; e.y = y;
    q.push_back(e);
  endtask
  task automatic idle(int n);
    repeat (n) begin
      @(posedge Clk); #1;
      ifc.de = 1'b0;
    end
  endtask
  task automatic frame();
    idle(3);
    @(posedge Clk); #1;
    ifc.VS = 1'b0;
    m_blink = m_over ? (m_blink + 1) % 32 : 0;
    m_map = ifc.map_1d;
    m_px = int'(ifc.playerX);
    m_py = int'(ifc.playerY);
    m_over = ifc.over;
    @(posedge Clk); #1;
    ifc.VS = 1'b1;
  endtask
  function automatic int clamp(int v);
    return v < 0 ? 0 : (v > 1023 ? 1023 : v);
  endfunction
  always @(negedge Clk) begin : mon
    exp_t e;
    if (ifc.de_out === 1'b1) begin
      n_checks++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pixel: de_out=1 rgb=%06h, none expected", {ifc.Red, ifc.Green, ifc.Blue});
      end else begin
        e = q.pop_front();
        if ({ifc.Red, ifc.Green, ifc.Blue} !== e.rgb) begin
          n_fail++;
          $display("FAIL pixel(%0d,%0d): got %06h expected %06h", e.x, e.y, {ifc.Red, ifc.Green, ifc.Blue}, e.rgb);
        end
        n_checks++;
        if (cyc - e.cyc != 2) begin
          n_fail++;
          $display("FAIL latency(%0d,%0d): got %0d expected 2", e.x, e.y, cyc - e.cyc);
        end
      end
    end
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    ifc.DrawX = 10'd0; ifc.DrawY = 10'd0; ifc.de = 1'b1; ifc.VS = 1'b1;
    ifc.map_1d = '1; ifc.playerX = 10'd300; ifc.playerY = 10'd300; ifc.over = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    n_checks++;
    if ({ifc.Red, ifc.Green, ifc.Blue} !== 24'h0) begin
      n_fail++; $display("FAIL reset_rgb: got %06h expected 000000", {ifc.Red, ifc.Green, ifc.Blue});
    end
    n_checks++;
    if (ifc.de_out !== 1'b0) begin
      n_fail++; $display("FAIL reset_de_out: got %b expected 0", ifc.de_out);
    end
    Reset_n = 1'b1;
    ifc.de = 1'b0;
    // inputs are not captured without a VS edge: shadow stays zero
    pix(100, 100); pix(0, 0); pix(40, 40);
    ifc.map_1d = '0; ifc.over = 1'b0; ifc.playerX = 10'd700; ifc.playerY = 10'd700;
    ifc.map_1d[21] = 1'b1;
    frame();
    pix(40, 40); pix(32, 40); pix(64, 40); pix(63, 63);
    ifc.playerX = 10'd100; ifc.playerY = 10'd200;
    frame();
    pix(100, 200); pix(131, 231); pix(132, 200); pix(99, 200); pix(100, 199); pix(131, 232);
    ifc.map_1d[22] = 1'b1;
    pix(80, 40); pix(40, 40);
    frame();
    pix(80, 40); pix(75, 50);
    ifc.map_1d[299] = 1'b1;
    frame();
    pix(640, 10); pix(639, 479); pix(620, 470); pix(10, 480); pix(1023, 1023);
    ifc.playerX = 10'd620; ifc.playerY = 10'd470;
    frame();
    pix(630, 475); pix(639, 479); pix(640, 475); pix(619, 470);
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 300; i++) ifc.map_1d[i] = ($urandom_range(0, 2) == 0);
      ifc.playerX = 10'($urandom_range(0, 700));
      ifc.playerY = 10'($urandom_range(0, 520));
      frame();
      for (int i = 0; i < 30; i++) pix($urandom_range(0, 700), $urandom_range(0, 520));
      for (int i = 0; i < 10; i++)
        pix(clamp(m_px + $urandom_range(0, 36) - 2), clamp(m_py + $urandom_range(0, 36) - 2));
      idle(1);
    end
    ifc.over = 1'b1;
    for (int f = 0; f < 40; f++) begin
      frame();
      pix($urandom_range(0, 639), $urandom_range(0, 479));
      pix(m_px < 640 ? m_px : 0, m_py < 480 ? m_py : 0);
      pix(700, 100);
    end
    ifc.over = 1'b0;
    frame();
    pix($urandom_range(0, 639), $urandom_range(0, 479)); pix(m_px < 640 ? m_px : 0, m_py < 480 ? m_py : 0);
    ifc.over = 1'b1;
    frame();
    pix($urandom_range(0, 639), $urandom_range(0, 479)); pix(5, 5);
    idle(6);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++; $display("FAIL drain: %0d pixels never appeared, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
